div_fifo_sequencer: RTL

Consumer stage for the divider input FIFO: pops one queued divide request at a time and runs a radix-2 restoring iterative divider on it. Returns a single XLEN result tagged with its instruction ID through a valid/ack handshake to writeback. Handles RISC-V DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed overflow.

---
 rtl/div_fifo_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/div_fifo_sequencer.sv
// Divider FIFO consumer: pops one request, runs a radix-2 restoring divide, returns an ID-tagged result.
// Optional DIV_RESULT_REUSE_EN macro: reuse the last quotient/remainder when operands and signedness repeat.
module div_fifo_sequencer #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ID_WIDTH = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fifo_valid,
   input  logic [XLEN-1:0]     fifo_rs1,
   input  logic [XLEN-1:0]     fifo_rs2,
   input  logic [1:0]          fifo_op,
   input  logic [ID_WIDTH-1:0] fifo_id,
   output logic                fifo_pop,
   output logic                result_valid,
   output logic [XLEN-1:0]     result_data,
   output logic [ID_WIDTH-1:0] result_id,
   input  logic                result_ack
);

   localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state;
   logic [CW-1:0]       counter;
   logic [XLEN-1:0]     quot, rem, divisor;
   logic                op_rem, neg_q, neg_r;
   logic [ID_WIDTH-1:0] id;

   logic                sgn_in;
   logic [XLEN-1:0]     abs_rs1, abs_rs2;
   logic [XLEN:0]       rem_sh, diff;
   logic [XLEN-1:0]     step_rem, step_quot, fin_rem, fin_quot;

   assign fifo_pop = (state == IDLE) & fifo_valid;

   always_comb begin
      sgn_in    = ~fifo_op[0];
      abs_rs1   = (sgn_in && fifo_rs1[XLEN-1]) ? -fifo_rs1 : fifo_rs1;
      abs_rs2   = (sgn_in && fifo_rs2[XLEN-1]) ? -fifo_rs2 : fifo_rs2;
      rem_sh    = {rem, quot[XLEN-1]};
      diff      = rem_sh - {1'b0, divisor};
      step_rem  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      step_quot = {quot[XLEN-2:0], ~diff[XLEN]};
      fin_quot  = neg_q ? -step_quot : step_quot;
      fin_rem   = neg_r ? -step_rem : step_rem;
   end

`ifdef DIV_RESULT_REUSE_EN
   logic            reuse_valid, reuse_sgn, reuse_hit;
   logic [XLEN-1:0] reuse_rs1, reuse_rs2, reuse_quot, reuse_rem;

   always_comb begin
      reuse_hit = reuse_valid && (fifo_rs1 == reuse_rs1) && (fifo_rs2 == reuse_rs2) &&
                  (sgn_in == reuse_sgn);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         counter      <= '0;
         result_valid <= 1'b0;
         result_data  <= '0;
         result_id    <= '0;
`ifdef DIV_RESULT_REUSE_EN
         reuse_valid  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (fifo_valid) begin
                  op_rem <= fifo_op[1];
                  id     <= fifo_id;
                  neg_q  <= sgn_in & (fifo_rs1[XLEN-1] ^ fifo_rs2[XLEN-1]);
                  neg_r  <= sgn_in & fifo_rs1[XLEN-1];
                  if (fifo_rs2 == '0) begin
                     state        <= DONE;
                     result_valid <= 1'b1;
                     result_id    <= fifo_id;
                     result_data  <= fifo_op[1] ? fifo_rs1 : '1;
                  end
`ifdef DIV_RESULT_REUSE_EN
                  else if (reuse_hit) begin
                     state        <= DONE;
                     result_valid <= 1'b1;
                     result_id    <= fifo_id;
                     result_data  <= fifo_op[1] ? reuse_rem : reuse_quot;
                  end
`endif
                  else begin
                     state   <= CALC;
                     counter <= '0;
                     quot    <= abs_rs1;
                     rem     <= '0;
                     divisor <= abs_rs2;
`ifdef DIV_RESULT_REUSE_EN
                     // Operand tags are safe to overwrite now: nothing compares them until DONE refreshes the results.
                     reuse_rs1 <= fifo_rs1;
                     reuse_rs2 <= fifo_rs2;
                     reuse_sgn <= sgn_in;
`endif
                  end
               end
            end
            CALC: begin
               quot    <= step_quot;
               rem     <= step_rem;
               counter <= counter + CW'(1);
               if (counter == LAST) begin
                  state        <= DONE;
                  result_valid <= 1'b1;
                  result_id    <= id;
                  result_data  <= op_rem ? fin_rem : fin_quot;
`ifdef DIV_RESULT_REUSE_EN
                  reuse_valid  <= 1'b1;
                  reuse_quot   <= fin_quot;
                  reuse_rem    <= fin_rem;
`endif
               end
            end
            DONE: begin
               if (result_ack) begin
                  state        <= IDLE;
                  result_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
